// File: rtl/hls_io_sequencer.sv
// Front-end sequencer for the HLS datapath/controller pair: loads operands,
// launches the controller, captures the result with run latency and timeout flag.
module hls_io_sequencer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_IN  = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ld_en,
    output logic [3:0]        ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              start,
    input  logic              op_ready,
    input  logic              done_next,
    input  logic [DATA_W-1:0] result_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [15:0]       out_cycles,
    output logic              busy
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned RUN_W = CNT_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_IN - 1);
    localparam logic [RUN_W-1:0] TIMEOUT_RUN = RUN_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_OUT    = 2'd3
    } state_e;

    state_e              state_q,      state_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic [CNT_W-1:0]    run_cnt_q,    run_cnt_d;
    logic [DATA_W-1:0]   out_data_q,   out_data_d;
    logic                out_err_q,    out_err_d;
    logic [CNT_W-1:0]    out_cycles_q, out_cycles_d;
    logic                out_valid_q,  out_valid_d;
    logic [RUN_W-1:0]    run_nxt;

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            idx_q        <= '0;
            run_cnt_q    <= '0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            out_cycles_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            run_cnt_q    <= run_cnt_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            out_cycles_q <= out_cycles_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Next-state and captured-result logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        run_cnt_d    = run_cnt_q;
        out_data_d   = out_data_q;
        out_err_d    = out_err_q;
        out_cycles_d = out_cycles_q;
        out_valid_d  = out_valid_q;
        run_nxt      = RUN_W'(run_cnt_q) + RUN_W'(1);

        unique case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                if (op_ready) begin
                    run_cnt_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + CNT_W'(1);
                // Completion takes priority over a coinciding timeout
                if (done_next) begin
                    out_data_d   = result_data;
                    out_cycles_d = run_nxt[CNT_W-1:0];
                    out_err_d    = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = ST_OUT;
                end else if (run_nxt == TIMEOUT_RUN) begin
                    out_data_d   = '0;
                    out_cycles_d = TIMEOUT_CNT;
                    out_err_d    = 1'b1;
                    out_valid_d  = 1'b1;
                    state_d      = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    idx_d       = '0;
                    out_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Handshake strobes, forced low while reset is asserted
    always_comb begin
        in_ready = 1'b0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        start    = 1'b0;
        busy     = 1'b0;

        if (!rst) begin
            busy = !((state_q == ST_LOAD) && (idx_q == '0));
            unique case (state_q)
                ST_LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        ld_en   = 1'b1;
                        ld_addr = idx_q;
                        ld_data = in_data;
                    end
                end
                ST_LAUNCH: start = op_ready;
                default: ;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign out_cycles = out_cycles_q;

endmodule

// File: tb/tb_hls_io_sequencer.sv
// Bench for hls_io_sequencer: table of jobs driven through load/launch/run/out,
// with loads and results checked against scoreboard queues.
module tb_hls_io_sequencer;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned NUM_IN  = 2;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ld_en;
    logic [3:0]        ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              start;
    logic              op_ready;
    logic              done_next;
    logic [DATA_W-1:0] result_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic [15:0]       out_cycles;
    logic              busy;

    hls_io_sequencer #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .op_ready(op_ready), .done_next(done_next),
        .result_data(result_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .out_cycles(out_cycles), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op0;
        logic [15:0] op1;
        int          launch_wait;
        int          done_at;      // RUN cycle carrying done_next; 0 = never
        logic [15:0] result;
        int          out_wait;
        logic [15:0] exp_data;
        logic        exp_err;
        logic [15:0] exp_cycles;
    } job_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } ld_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic [15:0] cycles;
    } res_t;

    ld_t  ld_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   start_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: loads, start pulses and result handshakes
    always @(negedge clk) begin
        if (!rst) begin
            if (start) start_cnt++;
            if (ld_en) begin
                if (ld_q.size() == 0) begin
                    check("ld_unexpected", 32'(ld_en), 32'd0);
                end else begin
                    ld_t e;
                    e = ld_q.pop_front();
                    check("ld_addr", 32'(ld_addr), 32'(e.addr));
                    check("ld_data", 32'(ld_data), 32'(e.data));
                end
            end
            if (out_valid && out_ready) begin
                if (res_q.size() == 0) begin
                    check("res_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("out_data", 32'(out_data), 32'(r.data));
                    check("out_err", 32'(out_err), 32'(r.err));
                    check("out_cycles", 32'(out_cycles), 32'(r.cycles));
                end
            end
        end
    end

    task automatic load_ops(input logic [15:0] op0, input logic [15:0] op1);
        logic [15:0] ops [2];
        ops[0] = op0;
        ops[1] = op1;
        for (int k = 0; k < 2; k++) begin
            ld_t e;
            int  budget;
            e.addr = 4'(k);
            e.data = ops[k];
            ld_q.push_back(e);
            in_valid = 1'b1;
            in_data  = ops[k];
            budget   = 0;
            @(negedge clk);
            while (!in_ready && budget < 20) begin
                tick();
                @(negedge clk);
                budget++;
            end
            check("in_ready_load", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic launch(input int wait_cycles);
        op_ready = 1'b0;
        for (int c = 0; c < wait_cycles; c++) begin
            @(negedge clk);
            check("start_held_low", 32'(start), 32'd0);
            tick();
        end
        op_ready = 1'b1;
        @(negedge clk);
        check("start_on_op_ready", 32'(start), 32'd1);
        tick();
        op_ready = 1'b0;
    endtask

    task automatic run_job(input job_t j);
        res_t r;
        int   budget;
        start_cnt = 0;
        r.data   = j.exp_data;
        r.err    = j.exp_err;
        r.cycles = j.exp_cycles;
        res_q.push_back(r);
        out_ready = 1'b0;

        load_ops(j.op0, j.op1);
        launch(j.launch_wait);
        result_data = j.result;
        if (j.done_at > 0) begin
            for (int c = 1; c < j.done_at; c++) tick();
            done_next = 1'b1;
            tick();
            done_next = 1'b0;
        end

        budget = 0;
        @(negedge clk);
        while (!out_valid && budget < 20) begin
            tick();
            @(negedge clk);
            budget++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        for (int c = 0; c < j.out_wait; c++) begin
            tick();
            @(negedge clk);
            check("out_valid_hold", 32'(out_valid), 32'd1);
            check("out_data_hold", 32'(out_data), 32'(j.exp_data));
            check("in_ready_in_out", 32'(in_ready), 32'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("start_count", 32'(start_cnt), 32'd1);
        tick();
    endtask

    job_t jobs [7];

    initial begin
        jobs[0] = '{16'h0003, 16'h0005, 0, 5, 16'h000F, 0, 16'h000F, 1'b0, 16'd5};
        jobs[1] = '{16'h0003, 16'h0005, 4, 5, 16'h000F, 0, 16'h000F, 1'b0, 16'd5};
        jobs[2] = '{16'h0003, 16'h0005, 0, 5, 16'h000F, 6, 16'h000F, 1'b0, 16'd5};
        jobs[3] = '{16'h0007, 16'h0009, 0, 0, 16'hBEEF, 2, 16'h0000, 1'b1, 16'd8};
        jobs[4] = '{16'h0011, 16'h0022, 1, 8, 16'h1234, 0, 16'h1234, 1'b0, 16'd8};
        jobs[5] = '{16'hFFFF, 16'h0000, 0, 1, 16'hA5A5, 1, 16'hA5A5, 1'b0, 16'd1};
        jobs[6] = '{16'h0101, 16'h0202, 2, 9, 16'h7777, 3, 16'h0000, 1'b1, 16'd8};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; op_ready = 1'b0;
        done_next = 1'b0; result_data = '0; out_ready = 1'b0;
        tick();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_cycles", 32'(out_cycles), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        for (int i = 0; i < 7; i++) run_job(jobs[i]);

        // Reset mid-RUN with a stale done_next around it
        start_cnt = 0;
        load_ops(16'h0033, 16'h0044);
        launch(0);
        result_data = 16'h9999;
        tick();
        tick();
        rst = 1'b1;
        done_next = 1'b1;
        @(negedge clk);
        check("mid_rst_start", 32'(start), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("stale_done_busy", 32'(busy), 32'd0);
        check("stale_done_valid", 32'(out_valid), 32'd0);
        check("stale_done_in_ready", 32'(in_ready), 32'd1);
        tick();
        done_next = 1'b0;
        check("ld_q_drained", 32'(ld_q.size()), 32'd0);
        run_job('{16'h0003, 16'h0005, 0, 3, 16'h0042, 0, 16'h0042, 1'b0, 16'd3});

        repeat (3) tick();
        check("res_q_drained", 32'(res_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hls_io_sequencer.md
Name: hls_io_sequencer

Overview:
- Front-end sequencer for the generated HLS datapath/controller pair.
- Accepts operands on a valid/ready input stream and writes them into the datapath input registers.
- Launches the controller via its start/op_ready handshake, waits for done_next, then captures the result.
- Presents the result on a valid/ready output stream together with a measured run latency and a timeout error flag.

Parameters:
- DATA_W, 16: operand and result width.
- NUM_IN, 2: operands loaded per job (1..15); loaded to addresses 0..NUM_IN-1.
- TIMEOUT, 255: maximum RUN cycles before abort (1..65535).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand available.
- in_data  in  DATA_W  operand value.
- in_ready  out  1  operand accepted when in_valid&in_ready.
- ld_en  out  1  datapath input-register write strobe.
- ld_addr  out  4  datapath input-register index.
- ld_data  out  DATA_W  value to write.
- start  out  1  job launch to controller.
- op_ready  in  1  controller idle and sampling start.
- done_next  in  1  controller completion pulse.
- result_data  in  DATA_W  datapath result register.
- out_valid  out  1  result available.
- out_data  out  DATA_W  captured result.
- out_err  out  1  job timed out; qualified by out_valid.
- out_cycles  out  16  RUN-cycle count of the job; qualified by out_valid.
- busy  out  1  high in any state except LOAD with idx==0.

Behaviour:
- Reset values (registered): state=LOAD, idx=0, run_cnt=0, out_data=0, out_err=0, out_cycles=0, out_valid=0. Combinational outputs are 0 under reset.
- Reset mid-job: returns to LOAD with idx=0; no start pulse is issued, and any captured result is discarded.
- LOAD state:
  - in_ready=1.
  - On accept: ld_en=1 in the same cycle, ld_addr=idx, ld_data=in_data; idx increments.
  - The accept at idx==NUM_IN-1 moves to LAUNCH.
- LAUNCH state:
  - start=op_ready (combinational).
  - If op_ready: run_cnt<=0, go to RUN. Otherwise hold; start stays 0.
- RUN state:
  - run_cnt increments each cycle.
  - If done_next: out_data<=result_data, out_cycles<=run_cnt+1, out_err<=0, go to OUT.
  - Else if run_cnt+1==TIMEOUT: out_data<=0, out_cycles<=TIMEOUT, out_err<=1, go to OUT.
  - done_next wins if it coincides with the timeout cycle.
- OUT state:
  - out_valid=1; out_data/out_err/out_cycles are held stable until accepted.
  - On out_ready: go to LOAD, idx<=0.
- Outside their owning states: in_ready=0, ld_en=0, start=0, out_valid=0.
  - in_valid, done_next and out_ready are ignored there; a done_next outside RUN has no effect.
- start is at most one cycle per job.
- Operand stream to next accept:
  - Operand stream to start: minimum 1 cycle after the last operand accept.
  - Back-to-back jobs: next in_ready one cycle after the out_valid&out_ready handshake.

Test Plan:
- NUM_IN=2, stream 0x0003 then 0x0005, op_ready=1, done_next 5 cycles after start with result 0x000F, out_ready=1 -> ld writes (0,3),(1,5); start one cycle; out_data=0x000F, out_cycles=5, out_err=0.
- Same job with op_ready held 0 for 4 cycles in LAUNCH -> start low for those 4 cycles, asserted exactly in the cycle op_ready rises; out_cycles still 5.
- out_ready held 0 for 6 cycles in OUT -> out_valid and out_data=0x000F stable for all 6; in_ready=0 throughout; LOAD resumes after handshake.
- TIMEOUT=8, done_next never asserted -> after 8 RUN cycles out_valid=1, out_err=1, out_data=0, out_cycles=8.
- done_next on the same cycle as the 8th RUN cycle (TIMEOUT=8) -> out_err=0, out_data=result_data, out_cycles=8.
- rst asserted in RUN after 2 cycles, then a fresh job -> start not reissued during reset, idx restarts at 0, new result reported correctly, stale done_next ignored.
